// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the subordinate state type.
// Latency: none (declarations and one combinational helper only).
// Backpressure: not applicable.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} sub_state_t;

    // Byte lanes touched by a transfer of the given size at the given address LSBs.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lsb;
            HSIZE_HALF: byte_en = lsb[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// MEM_DEPTH x 32 synchronous RAM with per-byte write enables and a registered read port.
// Latency: read data registered one cycle after rd_vld; writes land on the same edge.
// Backpressure: none; always ready.
module ahb_sram_mem #(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_dat,
    input  logic             rd_vld,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_dat
);

    logic [31:0] mem [MEM_DEPTH];

    // Byte-masked write; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    // Read register holds its value until the next read strobe.
    always_ff @(posedge clk) begin
        if (rst)         rd_dat <= '0;
        else if (rd_vld) rd_dat <= mem[rd_idx];
    end

endmodule

// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate over a word SRAM; wait-state counter built only with AHB_SUB_WAIT_EN.
// Latency: data phase completes 1 cycle after the address phase (+WAIT_STATES when enabled); errors take 2.
// Backpressure: HREADYOUT low during wait states and ERR1; next address phase accepted on the completing edge.
module ahb_sram_sub
    import ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    sub_state_t       state;
    logic             cap_write;
    logic [2:0]       cap_size;
    logic [1:0]       cap_lsb;
    logic [IDX_W-1:0] cap_idx;
    logic             data_done;

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      rd_idx;
    logic                  accept;
    logic                  addr_err;
    logic                  can_take;
    logic                  wr_commit;
    logic                  rd_en;
    logic                  hazard;
    logic [3:0]            wbe;
    logic [31:0]           mem_rdata;
    logic [3:0]            fwd_be;
    logic [31:0]           fwd_dat;
    logic                  unused_ok;

`ifdef AHB_SUB_WAIT_EN
    logic [3:0] wait_cnt;
    assign data_done = (wait_cnt == 4'd0);
`else
    assign data_done = 1'b1;
`endif

    assign offset   = HADDR - BASE_ADDR;
    assign rd_idx   = offset[IDX_W+1:2];
    assign accept   = HSEL && HTRANS[1] && HREADY;
    assign addr_err = (offset >= MEM_BYTES) || (HSIZE > HSIZE_WORD) ||
                      ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

    // A new address phase may only be taken when no data phase is still stalling.
    assign can_take  = (state == S_IDLE) || (state == S_ERR2) || ((state == S_DATA) && data_done);
    assign wr_commit = (state == S_DATA) && data_done && cap_write && !HRESET;
    assign rd_en     = can_take && accept && !addr_err && !HWRITE && !HRESET;
    assign hazard    = rd_en && wr_commit && (rd_idx == cap_idx);
    assign wbe       = byte_en(cap_size, cap_lsb);

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], offset[1:0], 4'(WAIT_STATES)};

    // Transfer FSM with registered HREADYOUT/HRESP and address-phase capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            cap_write <= 1'b0;
            cap_size  <= HSIZE_BYTE;
            cap_lsb   <= 2'b00;
            cap_idx   <= '0;
`ifdef AHB_SUB_WAIT_EN
            wait_cnt  <= 4'd0;
`endif
        end else begin
            case (state)
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
`ifdef AHB_SUB_WAIT_EN
                    if ((state == S_DATA) && (wait_cnt != 4'd0)) begin
                        wait_cnt  <= wait_cnt - 4'd1;
                        HREADYOUT <= (wait_cnt == 4'd1);
                    end else
`endif
                    if (accept) begin
                        cap_write <= HWRITE;
                        cap_size  <= HSIZE;
                        cap_lsb   <= HADDR[1:0];
                        cap_idx   <= rd_idx;
                        if (addr_err) begin
                            state     <= S_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else begin
                            state     <= S_DATA;
                            HRESP     <= HRESP_OKAY;
`ifdef AHB_SUB_WAIT_EN
                            wait_cnt  <= 4'(WAIT_STATES);
                            HREADYOUT <= (WAIT_STATES == 0);
`else
                            HREADYOUT <= 1'b1;
`endif
                        end
                    end else begin
                        state     <= S_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Remember which bytes of the read word were overwritten on the same edge.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_be  <= 4'b0000;
            fwd_dat <= '0;
        end else if (rd_en) begin
            fwd_be  <= hazard ? wbe : 4'b0000;
            fwd_dat <= HWDATA;
        end
    end

    // Merge forwarded write bytes over the RAM read word.
    always_comb begin
        HRDATA = mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (fwd_be[b]) HRDATA[8*b +: 8] = fwd_dat[8*b +: 8];
        end
    end

    ahb_sram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk    (HCLK),
        .rst    (HRESET),
        .wr_vld (wr_commit),
        .wr_be  (wbe),
        .wr_idx (cap_idx),
        .wr_dat (HWDATA),
        .rd_vld (rd_en),
        .rd_idx (rd_idx),
        .rd_dat (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Bench for ahb_sram_sub: AHB manager driver, transaction-level reference model, per-cycle compare.
// Latency: follows the DUT; expected data-phase length is 1 cycle plus the effective wait states.
// Backpressure: HREADY is tied to HREADYOUT, so the driver holds its address phase while stalled.
module tb_ahb_sram_sub;
    import ahb_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          WS    = 3;
`ifdef AHB_SUB_WAIT_EN
    localparam int          EW    = WS;
`else
    localparam int          EW    = 0;
`endif

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } item_t;

    logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    assign HREADY = HREADYOUT;

    ahb_sram_sub #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (DEPTH),
        .BASE_ADDR  (BASE), .WAIT_STATES (WS)
    ) dut (
        .HCLK (HCLK), .HRESET (HRESET), .HSEL (HSEL), .HADDR (HADDR), .HTRANS (HTRANS),
        .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (HBURST), .HPROT (HPROT),
        .HWDATA (HWDATA), .HREADY (HREADY), .HREADYOUT (HREADYOUT), .HRESP (HRESP),
        .HRDATA (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mref  [DEPTH*4];
    bit          known [DEPTH*4];
    bit          cur_vld = 0;
    bit          cur_err;
    item_t       cur;
    int          k;
    logic [31:0] exp_rd   = '0;
    logic [31:0] exp_mask = '1;
    bit          chk_en   = 0;
    bit          exp_rdy, exp_resp;
    int          low_cnt  = 0;
    int          resp_cnt = 0;

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] off;
        off = a - BASE;
        if (off >= DEPTH * 4) return 1'b1;
        if (s > 3'd2) return 1'b1;
        return (a % (32'd1 << s)) != 0;
    endfunction

    // Check this cycle's outputs, then advance the model across the next rising edge.
    always @(negedge HCLK) begin
        if (!cur_vld)     begin exp_rdy = 1'b1;         exp_resp = 1'b0; end
        else if (cur_err) begin exp_rdy = (k != 1);     exp_resp = 1'b1; end
        else              begin exp_rdy = (k == EW + 1); exp_resp = 1'b0; end
        if (chk_en) begin
            chk("hreadyout", 32'(HREADYOUT), 32'(exp_rdy));
            chk("hresp", 32'(HRESP), 32'(exp_resp));
            chk("hrdata", HRDATA & exp_mask, exp_rd & exp_mask);
            if (HREADYOUT === 1'b0) low_cnt++;
            if (HRESP === 1'b1) resp_cnt++;
        end
        if (HRESET) begin
            cur_vld  = 0;
            exp_rd   = '0;
            exp_mask = '1;
            chk_en   = 1;
        end else begin
            if (cur_vld && exp_rdy && !cur_err && cur.wr) begin
                logic [31:0] off;
                off = cur.addr - BASE;
                for (int j = 0; j < (1 << cur.size); j++) begin
                    mref[off + j]  = HWDATA[8*((off + j) % 4) +: 8];
                    known[off + j] = 1;
                end
            end
            if (!cur_vld || exp_rdy) begin
                if (HSEL && HTRANS[1]) begin
                    cur.addr = HADDR; cur.wr = HWRITE; cur.size = HSIZE;
                    cur_err  = is_err(HADDR, HSIZE);
                    cur_vld  = 1;
                    k        = 1;
                    if (!cur_err && !HWRITE) begin
                        logic [31:0] wb;
                        wb = (HADDR - BASE) & ~32'd3;
                        for (int b = 0; b < 4; b++) begin
                            exp_rd[8*b +: 8]   = mref[wb + b];
                            exp_mask[8*b +: 8] = known[wb + b] ? 8'hFF : 8'h00;
                        end
                    end
                end else begin
                    cur_vld = 0;
                end
            end else begin
                k++;
            end
        end
    end

    // ---------------- AHB manager driver ----------------
    item_t q[$];
    item_t a_item;
    logic  rdy_s = 1'b1;

    always @(negedge HCLK) rdy_s = HREADYOUT;

    initial begin
        a_item = '{sel: 1'b0, trans: HTRANS_IDLE, addr: 32'h0, wr: 1'b0, size: HSIZE_WORD, wdata: 32'h0};
        HSEL = 0; HTRANS = HTRANS_IDLE; HADDR = 0; HWRITE = 0; HSIZE = HSIZE_WORD;
        HWDATA = 0; HBURST = 0; HPROT = 0;
        forever begin
            @(posedge HCLK);
            #1;
            if (rdy_s === 1'b1) begin
                HWDATA = a_item.wdata;
                if (q.size() != 0) a_item = q.pop_front();
                else a_item = '{sel: 1'b0, trans: HTRANS_IDLE, addr: 32'h0, wr: 1'b0,
                                size: HSIZE_WORD, wdata: $urandom};
                HSEL = a_item.sel; HTRANS = a_item.trans; HADDR = a_item.addr;
                HWRITE = a_item.wr; HSIZE = a_item.size;
                HBURST = 3'($urandom); HPROT = 4'($urandom);
            end
        end
    end

    task automatic push(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic w, input logic [2:0] s, input logic [31:0] d);
        item_t it;
        it = '{sel: sel, trans: tr, addr: a, wr: w, size: s, wdata: d};
        q.push_back(it);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] v);
        push(1'b1, HTRANS_NONSEQ, a, 1'b1, s, v << (8 * a[1:0]));
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] s);
        push(1'b1, HTRANS_NONSEQ, a, 1'b0, s, $urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(posedge HCLK);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL drain: queue left %0d items, required 0", q.size());
        end
        repeat (EW + 6) @(posedge HCLK);
        @(negedge HCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] pre [32];
    int          low0, resp0, n;

    initial begin
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK); #1;
        chk("reset_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("reset_hresp", 32'(HRESP), 32'd0);
        chk("reset_hrdata", HRDATA, 32'h0);

        for (int w = 0; w < 32; w++) begin
            pre[w] = $urandom;
            wr(32'(w * 4), HSIZE_WORD, pre[w]);
        end
        drain();

        wr(32'h10, HSIZE_WORD, 32'hDEADBEEF);
        rd(32'h10, HSIZE_WORD);
        drain();
        chk("word_rd_dut", HRDATA, 32'hDEADBEEF);
        chk("word_rd_model", exp_rd, 32'hDEADBEEF);

        wr(32'h20, HSIZE_WORD, 32'h11223344);
        wr(32'h21, HSIZE_BYTE, 32'hAA);
        wr(32'h22, HSIZE_HALF, 32'h5566);
        rd(32'h20, HSIZE_WORD);
        drain();
        chk("lanes_dut", HRDATA, 32'h5566AA44);
        chk("lanes_model", exp_rd, 32'h5566AA44);

        wr(32'h40, HSIZE_WORD, 32'hCAFEF00D);
        rd(32'h40, HSIZE_WORD);
        drain();
        chk("hazard_dut", HRDATA, 32'hCAFEF00D);
        chk("hazard_model", exp_rd, 32'hCAFEF00D);

        resp0 = resp_cnt;
        rd(BASE + DEPTH * 4, HSIZE_WORD);
        drain();
        chk("oob_err_cycles", 32'(resp_cnt - resp0), 32'd2);
        chk("oob_hrdata_held", HRDATA, 32'hCAFEF00D);

        resp0 = resp_cnt;
        rd(32'h02, HSIZE_WORD);
        wr(32'h02, HSIZE_WORD, 32'h12345678);
        rd(32'h00, HSIZE_WORD);
        drain();
        chk("misalign_err_cycles", 32'(resp_cnt - resp0), 32'd4);
        chk("misalign_mem_intact", HRDATA, pre[0]);

        low0 = low_cnt;
        rd(32'h10, HSIZE_WORD);
        rd(32'h20, HSIZE_WORD);
        drain();
        chk("wait_low_cycles", 32'(low_cnt - low0), 32'(2 * EW));
        chk("wait_queued_rd", HRDATA, 32'h5566AA44);

        wr(32'h30, HSIZE_WORD, 32'hBAD0BAD0);
        n = 0;
        do begin
            @(posedge HCLK); #2;
            n++;
        end while (!(HTRANS == HTRANS_NONSEQ && HWRITE && HADDR == 32'h30) && n < 100);
        @(posedge HCLK); #2;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK); #1;
        chk("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("midrst_hresp", 32'(HRESP), 32'd0);
        chk("midrst_hrdata", HRDATA, 32'h0);
        rd(32'h30, HSIZE_WORD);
        drain();
        chk("midrst_no_write", HRDATA, pre[12]);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [2:0]  s;
            logic [1:0]  tr;
            int          r;
            r  = $urandom_range(0, 15);
            s  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = (r == 0) ? BASE + DEPTH * 4 + 32'($urandom_range(0, 63) * 4)
                          : BASE + 32'($urandom_range(0, 127));
            if (r != 1 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
            case ($urandom_range(0, 3))
                0:       tr = HTRANS_IDLE;
                1:       tr = HTRANS_BUSY;
                2:       tr = HTRANS_NONSEQ;
                default: tr = HTRANS_SEQ;
            endcase
            push($urandom_range(0, 7) != 0, tr, a, 1'($urandom), s, $urandom);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
